// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : mult_div_unit
// Description : Sequential 32-iteration multiply / divide unit for the
//               multicycle MIPS datapath. Radix-2 shift-add multiply and
//               restoring divide on operand magnitudes, with sign correction
//               applied in a final FIX cycle before HI/LO are written.
//               Optional feature macro: UNSIGNED_OPS_EN (enables multu/divu
//               through op_unsigned; when undefined all ops are signed).
// Revision    : 1.0 - initial release
// ============================================================================
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op_div,
    input  logic             op_unsigned,
    input  logic [WIDTH-1:0] a_operand,
    input  logic [WIDTH-1:0] b_operand,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [2:0] c_st_idle = 3'd0;
    localparam logic [2:0] c_st_run  = 3'd1;
    localparam logic [2:0] c_st_fix  = 3'd2;
    localparam logic [2:0] c_st_done = 3'd3;
    localparam logic [2:0] c_st_zero = 3'd4;

    localparam logic [5:0] c_last_iter = 6'(WIDTH - 1);

    logic [2:0]         r_state;
    logic [2:0]         w_state_nxt;
    logic [5:0]         r_cnt;
    // {upper accumulator / remainder (WIDTH+1), multiplier / quotient (WIDTH)}
    logic [2*WIDTH:0]   r_acc;
    // Multiplicand for multiply, divisor for divide (magnitude)
    logic [WIDTH-1:0]   r_opnd;
    logic               r_op_div;
    logic               r_neg_a;
    logic               r_neg_b;
    logic               r_dz;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic               w_signed;
    logic               w_accept;
    logic               w_div_zero_req;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;

    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH:0]   w_mul_next;
    logic [WIDTH:0]     w_rem_sh;
    logic [WIDTH-1:0]   w_quo_sh;
    logic [WIDTH+1:0]   w_div_diff;
    logic [2*WIDTH:0]   w_div_next;

    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quo_fix;
    logic [WIDTH-1:0]   w_rem_fix;

`ifdef UNSIGNED_OPS_EN
    assign w_signed = ~op_unsigned;
`else
    // op_unsigned has no effect in this build; every operation is signed
    logic w_unused_op_unsigned;
    assign w_unused_op_unsigned = op_unsigned;
    assign w_signed             = 1'b1;
`endif

    // Operand magnitudes and signs captured on acceptance
    assign w_a_neg = w_signed & a_operand[WIDTH-1];
    assign w_b_neg = w_signed & b_operand[WIDTH-1];
    assign w_a_mag = w_a_neg ? -a_operand : a_operand;
    assign w_b_mag = w_b_neg ? -b_operand : b_operand;

    assign w_accept       = start & ((r_state == c_st_idle) | (r_state == c_st_done));
    assign w_div_zero_req = op_div & (b_operand == '0);

    // Shift-add step: conditional add into the upper half, then shift right
    assign w_mul_sum  = r_acc[2*WIDTH:WIDTH] + (r_acc[0] ? {1'b0, r_opnd} : '0);
    assign w_mul_next = {1'b0, w_mul_sum, r_acc[WIDTH-1:1]};

    // Restoring divide step: shift remainder:quotient left, trial subtract
    assign w_rem_sh   = r_acc[2*WIDTH-1:WIDTH-1];
    assign w_quo_sh   = {r_acc[WIDTH-2:0], 1'b0};
    assign w_div_diff = {1'b0, w_rem_sh} - {2'b00, r_opnd};
    assign w_div_next = w_div_diff[WIDTH+1] ? {w_rem_sh, w_quo_sh}
                                            : {w_div_diff[WIDTH:0], w_quo_sh[WIDTH-1:1], 1'b1};

    // Sign correction; quotient truncates toward zero, remainder follows dividend
    assign w_prod     = r_acc[2*WIDTH-1:0];
    assign w_prod_fix = (r_neg_a ^ r_neg_b) ? -w_prod : w_prod;
    assign w_quo_fix  = (r_neg_a ^ r_neg_b) ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    assign w_rem_fix  = r_neg_a ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle, c_st_done: begin
                if (w_accept) begin
                    w_state_nxt = w_div_zero_req ? c_st_zero : c_st_run;
                end else begin
                    w_state_nxt = c_st_idle;
                end
            end
            c_st_run: begin
                if (r_cnt == c_last_iter) begin
                    w_state_nxt = c_st_fix;
                end
            end
            c_st_fix:  w_state_nxt = c_st_done;
            c_st_zero: w_state_nxt = c_st_done;
            default:   w_state_nxt = c_st_idle;
        endcase
    end

    // Operand capture, iteration datapath and HI/LO result registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt    <= '0;
            r_acc    <= '0;
            r_opnd   <= '0;
            r_op_div <= 1'b0;
            r_neg_a  <= 1'b0;
            r_neg_b  <= 1'b0;
            r_dz     <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else if (w_accept) begin
            r_cnt    <= '0;
            r_op_div <= op_div;
            r_neg_a  <= w_a_neg;
            r_neg_b  <= w_b_neg;
            r_dz     <= w_div_zero_req;
            r_opnd   <= op_div ? w_b_mag : w_a_mag;
            r_acc    <= {{(WIDTH+1){1'b0}}, (op_div ? w_a_mag : w_b_mag)};
        end else if (r_state == c_st_run) begin
            r_cnt <= r_cnt + 6'd1;
            r_acc <= r_op_div ? w_div_next : w_mul_next;
        end else if (r_state == c_st_fix) begin
            if (r_op_div) begin
                r_hi <= w_rem_fix;
                r_lo <= w_quo_fix;
            end else begin
                r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
                r_lo <= w_prod_fix[WIDTH-1:0];
            end
        end
    end

    assign busy     = (r_state == c_st_run) | (r_state == c_st_fix) | (r_state == c_st_zero);
    assign done     = (r_state == c_st_done);
    assign div_zero = done & r_dz;
    assign hi       = r_hi;
    assign lo       = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mult_div_unit
// Description : Self-checking bench for mult_div_unit. Directed scenarios
//               plus randomized operations checked against a plain-arithmetic
//               reference of the expected HI/LO contents.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        op_div;
    logic        op_unsigned;
    logic [31:0] a_operand;
    logic [31:0] b_operand;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;

    mult_div_unit #(.WIDTH(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .op_div      (op_div),
        .op_unsigned (op_unsigned),
        .a_operand   (a_operand),
        .b_operand   (b_operand),
        .busy        (busy),
        .done        (done),
        .div_zero    (div_zero),
        .hi          (hi),
        .lo          (lo)
    );

    always #5 clk = ~clk;

    // Reference: HI/LO contents after an operation, from integer arithmetic
    function automatic void ref_op(input logic [31:0] a, input logic [31:0] b,
                                   input bit div, input bit uns);
        bit     sgn;
        longint sa, sb, p, q, r;
`ifdef UNSIGNED_OPS_EN
        sgn = !uns;
`else
        sgn = 1'b1 | uns;
`endif
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'h0, a});
            sb = longint'({32'h0, b});
        end
        if (!div) begin
            p      = sa * sb;
            exp_hi = p[63:32];
            exp_lo = p[31:0];
        end else if (b != 32'h0) begin
            q      = sa / sb;
            r      = sa % sb;
            exp_hi = r[31:0];
            exp_lo = q[31:0];
        end
    endfunction

    // Pulse start for one cycle; returns at the negedge of cycle 1
    task automatic issue(input logic [31:0] a, input logic [31:0] b,
                         input bit div, input bit uns);
        a_operand   = a;
        b_operand   = b;
        op_div      = div;
        op_unsigned = uns;
        start       = 1'b1;
        @(negedge clk);
        start       = 1'b0;
    endtask

    // Wait (bounded) for done; reports cycle of done, busy cycles, overlap
    task automatic run_op(input int cyc0, output int cyc, output int bcnt,
                          output bit both);
        bit seen;
        cyc  = cyc0;
        bcnt = cyc0 - 1;
        seen = 1'b0;
        both = 1'b0;
        while (!seen && cyc <= 40) begin
            if (done) begin
                seen = 1'b1;
                both = busy;
            end else begin
                if (busy) bcnt++;
                @(negedge clk);
                cyc++;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; op_div = 1'b0; op_unsigned = 1'b0;
        a_operand = '0; b_operand = '0;
        repeat (3) @(negedge clk);
        n_vec++; if (busy !== 1'b0)     begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
        n_vec++; if (done !== 1'b0)     begin n_err++; $display("FAIL reset_done got %b want 0", done); end
        n_vec++; if (div_zero !== 1'b0) begin n_err++; $display("FAIL reset_div_zero got %b want 0", div_zero); end
        n_vec++; if (hi !== 32'h0)      begin n_err++; $display("FAIL reset_hi got %h want 0", hi); end
        n_vec++; if (lo !== 32'h0)      begin n_err++; $display("FAIL reset_lo got %h want 0", lo); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_signed_mul;
        int cyc, bcnt; bit both;
        @(negedge clk);
        ref_op(32'd7, 32'hFFFFFFFD, 1'b0, 1'b0);
        issue(32'd7, 32'hFFFFFFFD, 1'b0, 1'b0);
        run_op(1, cyc, bcnt, both);
        n_vec++; if (cyc !== 34)  begin n_err++; $display("FAIL mul_done_cycle got %0d want 34", cyc); end
        n_vec++; if (bcnt !== 33) begin n_err++; $display("FAIL mul_busy_cycles got %0d want 33", bcnt); end
        n_vec++; if (both !== 1'b0) begin n_err++; $display("FAIL mul_busy_with_done got %b want 0", both); end
        n_vec++; if (hi !== 32'hFFFFFFFF) begin n_err++; $display("FAIL mul_hi got %h want ffffffff", hi); end
        n_vec++; if (lo !== 32'hFFFFFFEB) begin n_err++; $display("FAIL mul_lo got %h want ffffffeb", lo); end
    endtask

    task automatic test_signed_div;
        int cyc, bcnt; bit both;
        @(negedge clk);
        ref_op(32'hFFFFFFF9, 32'd2, 1'b1, 1'b0);
        issue(32'hFFFFFFF9, 32'd2, 1'b1, 1'b0);
        run_op(1, cyc, bcnt, both);
        n_vec++; if (cyc !== 34) begin n_err++; $display("FAIL div_done_cycle got %0d want 34", cyc); end
        n_vec++; if (hi !== 32'hFFFFFFFF) begin n_err++; $display("FAIL div_hi got %h want ffffffff", hi); end
        n_vec++; if (lo !== 32'hFFFFFFFD) begin n_err++; $display("FAIL div_lo got %h want fffffffd", lo); end
        @(negedge clk);
        ref_op(32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b0);
        issue(32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b0);
        run_op(1, cyc, bcnt, both);
        n_vec++; if (div_zero !== 1'b0) begin n_err++; $display("FAIL divovf_div_zero got %b want 0", div_zero); end
        n_vec++; if (hi !== 32'h0) begin n_err++; $display("FAIL divovf_hi got %h want 0", hi); end
        n_vec++; if (lo !== 32'h80000000) begin n_err++; $display("FAIL divovf_lo got %h want 80000000", lo); end
    endtask

    task automatic test_div_zero;
        int cyc, bcnt; bit both;
        @(negedge clk);
        // 2774 / 53 leaves quotient 0x34 and remainder 0x12
        ref_op(32'd2774, 32'd53, 1'b1, 1'b0);
        issue(32'd2774, 32'd53, 1'b1, 1'b0);
        run_op(1, cyc, bcnt, both);
        n_vec++; if (hi !== 32'h12) begin n_err++; $display("FAIL preload_hi got %h want 12", hi); end
        n_vec++; if (lo !== 32'h34) begin n_err++; $display("FAIL preload_lo got %h want 34", lo); end
        @(negedge clk);
        issue(32'd5, 32'd0, 1'b1, 1'b0);
        run_op(1, cyc, bcnt, both);
        n_vec++; if (cyc !== 2)  begin n_err++; $display("FAIL dz_done_cycle got %0d want 2", cyc); end
        n_vec++; if (bcnt !== 1) begin n_err++; $display("FAIL dz_busy_cycles got %0d want 1", bcnt); end
        n_vec++; if (div_zero !== 1'b1) begin n_err++; $display("FAIL dz_flag got %b want 1", div_zero); end
        n_vec++; if (hi !== 32'h12) begin n_err++; $display("FAIL dz_hi got %h want 12", hi); end
        n_vec++; if (lo !== 32'h34) begin n_err++; $display("FAIL dz_lo got %h want 34", lo); end
        @(negedge clk);
        n_vec++; if (div_zero !== 1'b0) begin n_err++; $display("FAIL dz_flag_clears got %b want 0", div_zero); end
    endtask

    task automatic test_start_while_busy;
        int cyc, bcnt; bit both;
        @(negedge clk);
        ref_op(32'h00012345, 32'hFFFFF001, 1'b0, 1'b0);
        issue(32'h00012345, 32'hFFFFF001, 1'b0, 1'b0);
        repeat (9) @(negedge clk);
        issue(32'd100, 32'd0, 1'b1, 1'b0);
        a_operand = 32'hDEADBEEF;
        b_operand = 32'h00000003;
        run_op(11, cyc, bcnt, both);
        n_vec++; if (cyc !== 34) begin n_err++; $display("FAIL swb_done_cycle got %0d want 34", cyc); end
        n_vec++; if (div_zero !== 1'b0) begin n_err++; $display("FAIL swb_div_zero got %b want 0", div_zero); end
        n_vec++; if (hi !== exp_hi) begin n_err++; $display("FAIL swb_hi got %h want %h", hi, exp_hi); end
        n_vec++; if (lo !== exp_lo) begin n_err++; $display("FAIL swb_lo got %h want %h", lo, exp_lo); end
    endtask

    task automatic test_back_to_back;
        int cyc, bcnt; bit both;
        @(negedge clk);
        ref_op(32'hFFFF0000, 32'h00010001, 1'b0, 1'b0);
        issue(32'hFFFF0000, 32'h00010001, 1'b0, 1'b0);
        run_op(1, cyc, bcnt, both);
        n_vec++; if (hi !== exp_hi) begin n_err++; $display("FAIL b2b_first_hi got %h want %h", hi, exp_hi); end
        n_vec++; if (lo !== exp_lo) begin n_err++; $display("FAIL b2b_first_lo got %h want %h", lo, exp_lo); end
        ref_op(32'h7FFFFFFF, 32'hFFFFFF00, 1'b1, 1'b0);
        issue(32'h7FFFFFFF, 32'hFFFFFF00, 1'b1, 1'b0);
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL b2b_busy_rise got %b want 1", busy); end
        run_op(1, cyc, bcnt, both);
        n_vec++; if (cyc !== 34) begin n_err++; $display("FAIL b2b_done_cycle got %0d want 34", cyc); end
        n_vec++; if (hi !== exp_hi) begin n_err++; $display("FAIL b2b_second_hi got %h want %h", hi, exp_hi); end
        n_vec++; if (lo !== exp_lo) begin n_err++; $display("FAIL b2b_second_lo got %h want %h", lo, exp_lo); end
    endtask

    task automatic test_reset_mid;
        int ndone;
        @(negedge clk);
        issue(32'h11111111, 32'h22222222, 1'b0, 1'b0);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_hi = '0;
        exp_lo = '0;
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rmid_busy got %b want 0", busy); end
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL rmid_done got %b want 0", done); end
        n_vec++; if (hi !== 32'h0)  begin n_err++; $display("FAIL rmid_hi got %h want 0", hi); end
        n_vec++; if (lo !== 32'h0)  begin n_err++; $display("FAIL rmid_lo got %h want 0", lo); end
        ndone = 0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) ndone++;
        end
        n_vec++; if (ndone !== 0) begin n_err++; $display("FAIL rmid_activity got %0d want 0", ndone); end
    endtask

    task automatic test_unsigned;
        int cyc, bcnt; bit both;
        logic [31:0] want_hi;
`ifdef UNSIGNED_OPS_EN
        want_hi = 32'hFFFFFFFE;
`else
        want_hi = 32'h00000000;
`endif
        @(negedge clk);
        ref_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1);
        issue(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1);
        run_op(1, cyc, bcnt, both);
        n_vec++; if (hi !== want_hi) begin n_err++; $display("FAIL uns_hi got %h want %h", hi, want_hi); end
        n_vec++; if (lo !== 32'h1)   begin n_err++; $display("FAIL uns_lo got %h want 00000001", lo); end
    endtask

    task automatic test_random;
        int cyc, bcnt; bit both;
        logic [31:0] a, b;
        bit div, uns, zero;
        for (int i = 0; i < 30; i++) begin
            a = $urandom;
            case ($urandom_range(0, 4))
                0:       b = 32'h0;
                1:       b = $urandom_range(1, 15);
                2:       b = -($urandom_range(1, 15));
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 5) == 0) a = 32'h80000000;
            div  = 1'($urandom_range(0, 1));
            uns  = 1'($urandom_range(0, 1));
            zero = div && (b == 32'h0);
            @(negedge clk);
            ref_op(a, b, div, uns);
            issue(a, b, div, uns);
            run_op(1, cyc, bcnt, both);
            n_vec++; if (cyc !== (zero ? 2 : 34)) begin n_err++; $display("FAIL rnd%0d_done_cycle got %0d want %0d", i, cyc, zero ? 2 : 34); end
            n_vec++; if (div_zero !== zero) begin n_err++; $display("FAIL rnd%0d_div_zero got %b want %b", i, div_zero, zero); end
            n_vec++; if (both !== 1'b0) begin n_err++; $display("FAIL rnd%0d_busy_with_done got %b want 0", i, both); end
            n_vec++; if (hi !== exp_hi) begin n_err++; $display("FAIL rnd%0d_hi a=%h b=%h div=%b uns=%b got %h want %h", i, a, b, div, uns, hi, exp_hi); end
            n_vec++; if (lo !== exp_lo) begin n_err++; $display("FAIL rnd%0d_lo a=%h b=%h div=%b uns=%b got %h want %h", i, a, b, div, uns, lo, exp_lo); end
        end
    endtask

    initial begin
        test_reset;
        test_signed_mul;
        test_signed_div;
        test_div_zero;
        test_start_while_busy;
        test_back_to_back;
        test_reset_mid;
        test_unsigned;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
